hd44780_lcd_writer: RTL and testbench

- Parametrised successor to the single-nybble LCD sender: accepts a full byte transfer request and drives the HD44780 pins.
- Supports a 4-bit or 8-bit LCD bus and emits one or two E pulses with programmable tAS/PWEH/tcycE timing.
- Applies the post-command execution delay itself, including the long delay for clear/home commands.
- Sits between the LCD init/controller state machine and the top-level LCD pins; the controller no longer needs the external state timer for per-command waits.

---
 rtl/hd44780_lcd_writer.sv | 140 ++++++++++++++
 tb/tb_hd44780_lcd_writer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hd44780_lcd_writer.sv
// HD44780 byte writer: accepts an RS+byte request, pulses E once (8-bit or nybble-only) or twice (4-bit), then waits out the execution time.
// Busy for N*TICKS_TCYCE + exec wait after accept; ACK_O on the first IDLE cycle; STB_I while busy is dropped, not queued.
module hd44780_lcd_writer #(
    parameter int BUS_WIDTH     = 4,
    parameter int TICKS_TAS     = 3,
    parameter int TICKS_PWEH    = 22,
    parameter int TICKS_TCYCE   = 48,
    parameter int TICKS_EXEC    = 2544,
    parameter int TICKS_CLRHOME = 76800,
    parameter int COUNT_BITS    = 23
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 STB_I,
    input  logic                 i_rs,
    input  logic [7:0]           i_data,
    input  logic                 i_nybble_only,
    output logic                 o_busy,
    output logic                 ACK_O,
    output logic                 o_rs,
    output logic                 o_e,
    output logic [BUS_WIDTH-1:0] o_lcd_data
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_EHIGH = 3'd2;
    localparam logic [2:0] ST_EHOLD = 3'd3;
    localparam logic [2:0] ST_EXEC  = 3'd4;

    localparam bit IS_BUS4 = (BUS_WIDTH != 8);

    localparam logic [COUNT_BITS-1:0] LD_TAS  = COUNT_BITS'(TICKS_TAS - 1);
    localparam logic [COUNT_BITS-1:0] LD_PWEH = COUNT_BITS'(TICKS_PWEH - 1);
    localparam logic [COUNT_BITS-1:0] LD_HOLD = COUNT_BITS'(TICKS_TCYCE - TICKS_TAS - TICKS_PWEH - 1);
    localparam logic [COUNT_BITS-1:0] LD_EXEC = COUNT_BITS'(TICKS_EXEC - 1);
    localparam logic [COUNT_BITS-1:0] LD_CLRH = COUNT_BITS'(TICKS_CLRHOME - 1);

    logic [2:0]            state;
    logic [COUNT_BITS-1:0] cnt;
    logic [7:0]            data_q;
    logic                  rs_q;
    logic                  nyb_q;
    logic                  second_pending;
    logic                  clrhome;
    logic                  cnt_done;
    logic [BUS_WIDTH-1:0]  first_unit;
    logic [BUS_WIDTH-1:0]  second_unit;

    generate
        if (BUS_WIDTH == 8) begin : g_bus8
            assign first_unit  = i_data;
            assign second_unit = data_q;
        end else begin : g_bus4
            assign first_unit  = i_data[7:4];
            assign second_unit = data_q[3:0];
        end
    endgenerate

    // Clear (0x01) and home (0x02/0x03) need the long wait; nybble-only init writes never do.
    assign clrhome  = !rs_q && !nyb_q && (data_q[7:2] == 6'd0) && (data_q != 8'd0);
    assign cnt_done = (cnt == '0);

    assign o_busy = (state != ST_IDLE);
    assign o_e    = (state == ST_EHIGH);

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            data_q         <= 8'd0;
            rs_q           <= 1'b0;
            nyb_q          <= 1'b0;
            second_pending <= 1'b0;
            ACK_O          <= 1'b0;
            o_rs           <= 1'b0;
            o_lcd_data     <= '0;
        end else begin
            ACK_O <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (STB_I) begin
                        state          <= ST_SETUP;
                        cnt            <= LD_TAS;
                        data_q         <= i_data;
                        rs_q           <= i_rs;
                        nyb_q          <= IS_BUS4 && i_nybble_only;
                        second_pending <= IS_BUS4 && !i_nybble_only;
                        o_rs           <= i_rs;
                        o_lcd_data     <= first_unit;
                    end
                end
                ST_SETUP: begin
                    if (cnt_done) begin
                        state <= ST_EHIGH;
                        cnt   <= LD_PWEH;
                    end else begin
                        cnt <= cnt - COUNT_BITS'(1);
                    end
                end
                ST_EHIGH: begin
                    if (cnt_done) begin
                        state <= ST_EHOLD;
                        cnt   <= LD_HOLD;
                    end else begin
                        cnt <= cnt - COUNT_BITS'(1);
                    end
                end
                ST_EHOLD: begin
                    if (cnt_done) begin
                        if (second_pending) begin
                            second_pending <= 1'b0;
                            o_lcd_data     <= second_unit;
                            state          <= ST_SETUP;
                            cnt            <= LD_TAS;
                        end else begin
                            state <= ST_EXEC;
                            cnt   <= clrhome ? LD_CLRH : LD_EXEC;
                        end
                    end else begin
                        cnt <= cnt - COUNT_BITS'(1);
                    end
                end
                ST_EXEC: begin
                    if (cnt_done) begin
                        state <= ST_IDLE;
                        ACK_O <= 1'b1;
                    end else begin
                        cnt <= cnt - COUNT_BITS'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hd44780_lcd_writer.sv
// Bench for hd44780_lcd_writer: a 4-bit and an 8-bit instance checked cycle by cycle against a timeline model.
module tb_hd44780_lcd_writer;

    localparam int TAS   = 2;
    localparam int PWEH  = 4;
    localparam int TCYCE = 10;
    localparam int EXEC  = 20;
    localparam int CLRH  = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       stb4, rs4, nyb4, busy4, ack4, ors4, oe4;
    logic [7:0] d4;
    logic [3:0] lcd4;
    logic       stb8, rs8, nyb8, busy8, ack8, ors8, oe8;
    logic [7:0] d8;
    logic [7:0] lcd8;

    int n_tests = 0;
    int n_fail  = 0;

    hd44780_lcd_writer #(
        .BUS_WIDTH(4), .TICKS_TAS(TAS), .TICKS_PWEH(PWEH), .TICKS_TCYCE(TCYCE),
        .TICKS_EXEC(EXEC), .TICKS_CLRHOME(CLRH), .COUNT_BITS(23)
    ) u_dut4 (
        .CLK_I(clk), .RST_I(rst_n), .STB_I(stb4), .i_rs(rs4), .i_data(d4),
        .i_nybble_only(nyb4), .o_busy(busy4), .ACK_O(ack4), .o_rs(ors4),
        .o_e(oe4), .o_lcd_data(lcd4)
    );

    hd44780_lcd_writer #(
        .BUS_WIDTH(8), .TICKS_TAS(TAS), .TICKS_PWEH(PWEH), .TICKS_TCYCE(TCYCE),
        .TICKS_EXEC(EXEC), .TICKS_CLRHOME(CLRH), .COUNT_BITS(23)
    ) u_dut8 (
        .CLK_I(clk), .RST_I(rst_n), .STB_I(stb8), .i_rs(rs8), .i_data(d8),
        .i_nybble_only(nyb8), .o_busy(busy8), .ACK_O(ack8), .o_rs(ors8),
        .o_e(oe8), .o_lcd_data(lcd8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Model: E pulses per transfer.
    function automatic int n_units(input bit w8, input bit nyb);
        if (w8) return 1;
        return nyb ? 1 : 2;
    endfunction

    // Model: post-command wait in clocks.
    function automatic int wait_ticks(input bit w8, input logic rs, input logic [7:0] d, input bit nyb);
        if (!rs && !(nyb && !w8) && d >= 8'd1 && d <= 8'd3) return CLRH;
        return EXEC;
    endfunction

    task automatic drive(input bit w8, input logic s, input logic r, input logic [7:0] dd, input logic nb);
        if (w8) begin
            stb8 = s; rs8 = r; d8 = dd; nyb8 = nb;
        end else begin
            stb4 = s; rs4 = r; d4 = dd; nyb4 = nb;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy4"}, {31'd0, busy4}, 32'd0);
        check({tag, " ack4"},  {31'd0, ack4},  32'd0);
        check({tag, " e4"},    {31'd0, oe4},   32'd0);
        check({tag, " busy8"}, {31'd0, busy8}, 32'd0);
        check({tag, " ack8"},  {31'd0, ack8},  32'd0);
        check({tag, " e8"},    {31'd0, oe8},   32'd0);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check_idle("idle");
        end
    endtask

    // Called at the negedge of an IDLE cycle; returns at the negedge of the ACK cycle.
    task automatic xfer(input bit w8, input logic rs, input logic [7:0] d, input bit nyb, input bit noise);
        int n, len;
        logic e_exp;
        logic [7:0] d_exp;
        logic [31:0] lcd_got;
        string tg;
        n   = n_units(w8, nyb);
        len = n * TCYCE + wait_ticks(w8, rs, d, nyb);
        drive(w8, 1'b1, rs, d, nyb);
        for (int t = 1; t <= len + 1; t++) begin
            @(negedge clk);
            e_exp = 1'b0;
            for (int p = 0; p < n; p++)
                if (t >= p * TCYCE + TAS + 1 && t <= p * TCYCE + TAS + PWEH) e_exp = 1'b1;
            if (w8)                       d_exp = d;
            else if (n == 2 && t > TCYCE) d_exp = {4'h0, d[3:0]};
            else                          d_exp = {4'h0, d[7:4]};
            lcd_got = w8 ? {24'd0, lcd8} : {28'd0, lcd4};
            tg = $sformatf("w%0d d=%02h rs=%0b nyb=%0b t=%0d", w8 ? 8 : 4, d, rs, nyb, t);
            check({tg, " busy"}, {31'd0, w8 ? busy8 : busy4}, {31'd0, t <= len});
            check({tg, " ack"},  {31'd0, w8 ? ack8 : ack4},   {31'd0, t == len + 1});
            check({tg, " e"},    {31'd0, w8 ? oe8 : oe4},     {31'd0, e_exp});
            check({tg, " rs"},   {31'd0, w8 ? ors8 : ors4},   {31'd0, rs});
            check({tg, " lcd"},  lcd_got, {24'd0, d_exp});
            if (t <= len)
                drive(w8, noise ? ($urandom % 6 == 0) : 1'b0, 1'($urandom), 8'($urandom), 1'($urandom));
            else
                drive(w8, 1'b0, 1'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        bit w8, nyb, noise;
        logic rs;
        logic [7:0] d;

        stb4 = 0; rs4 = 0; d4 = 0; nyb4 = 0;
        stb8 = 0; rs8 = 0; d8 = 0; nyb8 = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset rs4",  {31'd0, ors4}, 32'd0);
        check("reset lcd4", {28'd0, lcd4}, 32'd0);
        check("reset rs8",  {31'd0, ors8}, 32'd0);
        check("reset lcd8", {24'd0, lcd8}, 32'd0);
        rst_n = 1;
        idle_cycles(2);

        xfer(0, 1'b1, 8'h48, 0, 0);  idle_cycles(2);
        xfer(0, 1'b0, 8'h01, 0, 0);  idle_cycles(1);
        xfer(0, 1'b0, 8'h03, 0, 0);  idle_cycles(1);
        xfer(0, 1'b0, 8'h04, 0, 0);  idle_cycles(1);
        xfer(0, 1'b0, 8'h02, 0, 0);  idle_cycles(1);
        xfer(0, 1'b0, 8'h30, 1, 0);  idle_cycles(1);
        xfer(0, 1'b0, 8'h01, 1, 0);  idle_cycles(1);
        xfer(1, 1'b1, 8'hA5, 0, 0);  idle_cycles(1);
        xfer(1, 1'b0, 8'h01, 1, 0);  idle_cycles(1);
        xfer(1, 1'b0, 8'h00, 0, 0);  idle_cycles(1);

        // Back-to-back with STB_I kept high across the ACK cycle, plus spurious strobes mid-transfer.
        xfer(0, 1'b1, 8'h5A, 0, 1);
        xfer(0, 1'b0, 8'h02, 0, 1);
        xfer(0, 1'b1, 8'hC3, 1, 1);
        idle_cycles(2);

        // Asynchronous reset during the first E-high phase.
        drive(0, 1'b1, 1'b1, 8'h48, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("pre-reset e4", {31'd0, oe4}, 32'd1);
        #2 rst_n = 0;
        #1;
        check("arst e4",    {31'd0, oe4},   32'd0);
        check("arst busy4", {31'd0, busy4}, 32'd0);
        check("arst ack4",  {31'd0, ack4},  32'd0);
        check("arst rs4",   {31'd0, ors4},  32'd0);
        check("arst lcd4",  {28'd0, lcd4},  32'd0);
        repeat (2) begin
            @(negedge clk);
            check_idle("in-reset");
        end
        rst_n = 1;
        idle_cycles(60);
        xfer(0, 1'b1, 8'h48, 0, 0);
        idle_cycles(1);

        for (int k = 0; k < 30; k++) begin
            w8    = ($urandom % 3 == 0);
            rs    = 1'($urandom);
            d     = ($urandom % 3 == 0) ? 8'($urandom % 5) : 8'($urandom);
            nyb   = ($urandom % 4 == 0);
            noise = 1'($urandom);
            xfer(w8, rs, d, nyb, noise);
            idle_cycles(int'($urandom % 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
